updown_decoder: RTL

UPDOWN_DECODER -- requirements
Module: updown_decoder

---
 rtl/updown_decoder_pkg.sv | 22 ++
 rtl/updown_decoder_step_class.sv | 26 ++
 rtl/updown_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/updown_decoder_pkg.sv
// Shared definitions for the up/down counter decoder: data width, decoder
// states and the step classes produced by the classifier.
package updown_decoder_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_STAY = 2'd0,
    CLS_UP   = 2'd1,
    CLS_DOWN = 2'd2,
    CLS_JUMP = 2'd3
  } step_t;

endpackage

// File: rtl/updown_decoder_step_class.sv
// Combinational step classifier: compares a new counter sample with the
// previous one using modulo-2^DATA_W arithmetic so wrap-around is a legal step.
module updown_step_class
  import updown_decoder_pkg::*;
(
  input  logic [DATA_W-1:0] i_prev,
  input  logic [DATA_W-1:0] i_q,
  output step_t             o_class
);

  logic [DATA_W-1:0] w_delta;

  assign w_delta = i_q - i_prev;

  always_comb begin
    o_class = CLS_JUMP;
    if (w_delta == '0) begin
      o_class = CLS_STAY;
    end else if (w_delta == {{(DATA_W-1){1'b0}}, 1'b1}) begin
      o_class = CLS_UP;
    end else if (w_delta == '1) begin
      o_class = CLS_DOWN;
    end
  end

endmodule

// File: rtl/updown_decoder.sv
// Up/down counter decoder: tracks an observed counter, reports direction,
// pauses, legal reversals and illegal jumps with a saturating error count.
module updown_decoder
  import updown_decoder_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              SMP_EN,
  input  logic [DATA_W-1:0] Q_IN,
  input  logic              CLR_ERR,
  output logic              DIR,
  output logic              HOLD,
  output logic              LOCK,
  output logic              DIR_CHG,
  output logic              ERR,
  output logic [DATA_W-1:0] ERR_CNT
);

  state_t            r_state;
  logic [DATA_W-1:0] r_prev;
  logic              r_dir;
  logic              r_hold;
  logic              r_lock;
  logic              r_dir_chg;
  logic              r_err;
  logic [DATA_W-1:0] r_err_cnt;

  state_t            w_state_next;
  logic [DATA_W-1:0] w_prev_next;
  logic              w_dir_next;
  logic              w_hold_next;
  logic              w_lock_next;
  logic              w_dir_chg_next;
  logic              w_err_next;
  logic [DATA_W-1:0] w_err_cnt_base;
  logic [DATA_W-1:0] w_err_cnt_next;
  step_t             w_class;
  logic              w_is_step;
  logic              w_step_up;

  updown_step_class u_step_class (
    .i_prev  (r_prev),
    .i_q     (Q_IN),
    .o_class (w_class)
  );

  assign w_is_step = (w_class == CLS_UP) || (w_class == CLS_DOWN);
  assign w_step_up = (w_class == CLS_UP);

  always_comb begin
    w_state_next   = r_state;
    w_prev_next    = r_prev;
    w_dir_next     = r_dir;
    w_hold_next    = r_hold;
    w_lock_next    = r_lock;
    w_dir_chg_next = 1'b0;
    w_err_next     = 1'b0;
    if (SMP_EN) begin
      w_prev_next = Q_IN;
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_ACQ;
        end
        ST_ACQ: begin
          // HOLD mirrors whether this sample repeated the last one.
          w_hold_next = (w_class == CLS_STAY);
          if (w_is_step) begin
            w_dir_next   = w_step_up;
            w_lock_next  = 1'b1;
            w_state_next = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_is_step) begin
            w_hold_next = 1'b0;
            if (w_step_up != r_dir) begin
              w_dir_next     = w_step_up;
              w_dir_chg_next = 1'b1;
            end
          end else if (w_class == CLS_STAY) begin
            w_hold_next = 1'b1;
          end else begin
            w_err_next   = 1'b1;
            w_lock_next  = 1'b0;
            w_hold_next  = 1'b0;
            w_state_next = ST_ACQ;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Clear takes effect first so a coincident error leaves a count of one.
  always_comb begin
    w_err_cnt_base = CLR_ERR ? '0 : r_err_cnt;
    w_err_cnt_next = w_err_cnt_base;
    if (w_err_next && (w_err_cnt_base != CNT_MAX)) begin
      w_err_cnt_next = w_err_cnt_base + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_prev    <= '0;
      r_dir     <= 1'b0;
      r_hold    <= 1'b0;
      r_lock    <= 1'b0;
      r_dir_chg <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_prev    <= w_prev_next;
      r_dir     <= w_dir_next;
      r_hold    <= w_hold_next;
      r_lock    <= w_lock_next;
      r_dir_chg <= w_dir_chg_next;
      r_err     <= w_err_next;
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign DIR     = r_dir;
  assign HOLD    = r_hold;
  assign LOCK    = r_lock;
  assign DIR_CHG = r_dir_chg;
  assign ERR     = r_err;
  assign ERR_CNT = r_err_cnt;

endmodule
